// File: rtl/mem_wb_stage_pkg.sv
// Shared pipeline definitions for the MEM/WB stage.
// Load-type encodings, default widths and the bubble constant.
package mem_wb_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam logic [2:0] LD_W  = 3'd0;
  localparam logic [2:0] LD_H  = 3'd1;
  localparam logic [2:0] LD_HU = 3'd2;
  localparam logic [2:0] LD_B  = 3'd3;
  localparam logic [2:0] LD_BU = 3'd4;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic misalign;
  } wb_ctrl_t;

  localparam wb_ctrl_t WB_BUBBLE = '0;

endpackage

// File: rtl/mem_wb_stage_load_extend.sv
// Little-endian byte/halfword lane select with sign/zero extension.
// Purely combinational; shared with the forwarding path.
module load_extend
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        off_i,
  input  logic [2:0]        load_type_i,
  output logic [DATA_W-1:0] ext_o,
  output logic              misalign_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  always_comb begin
    byte_s = rdata_i[7:0];
    unique case (off_i)
      2'd0: byte_s = rdata_i[7:0];
      2'd1: byte_s = rdata_i[15:8];
      2'd2: byte_s = rdata_i[23:16];
      2'd3: byte_s = rdata_i[31:24];
    endcase
    half_s = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    ext_o      = rdata_i;
    misalign_o = 1'b0;
    case (load_type_i)
      LD_H: begin
        ext_o      = {{(DATA_W-16){half_s[15]}}, half_s};
        misalign_o = off_i[0];
      end
      LD_HU: begin
        ext_o      = {{(DATA_W-16){1'b0}}, half_s};
        misalign_o = off_i[0];
      end
      LD_B:  ext_o = {{(DATA_W-8){byte_s[7]}}, byte_s};
      LD_BU: ext_o = {{(DATA_W-8){1'b0}}, byte_s};
      // LW and the unused encodings 5-7
      default: begin
        ext_o      = rdata_i;
        misalign_o = (off_i != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back formatter.
// Drives the register-file write port plus misalign flag and retire counter.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_reg_write,
  input  logic              in_mem_to_reg,
  input  logic [2:0]        in_load_type,
  input  logic [ADDR_W-1:0] in_write_addr,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_rdata,
  output logic              reg_write,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic              wb_valid,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  retired_count
);

  logic [DATA_W-1:0] ext_s;
  logic              ld_mis_s;

  load_extend #(.DATA_W(DATA_W)) u_ext (
    .rdata_i     (in_mem_rdata),
    .off_i       (in_alu_result[1:0]),
    .load_type_i (in_load_type),
    .ext_o       (ext_s),
    .misalign_o  (ld_mis_s)
  );

  wb_ctrl_t          ctrl_d, ctrl_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [DATA_W-1:0] data_d, data_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;

  always_comb begin
    ctrl_d.valid    = in_valid;
    ctrl_d.misalign = in_valid & in_mem_to_reg & ld_mis_s;
    ctrl_d.reg_write = in_valid & in_reg_write
                     & (|in_write_addr) & ~ctrl_d.misalign;
    addr_d = in_write_addr;
    data_d = in_mem_to_reg ? ext_s : in_alu_result;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q <= WB_BUBBLE;
      addr_q <= '0;
      data_q <= '0;
    end else if (flush) begin
      ctrl_q <= WB_BUBBLE;
      addr_q <= '0;
      data_q <= '0;
    end else if (!stall) begin
      ctrl_q <= ctrl_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  // The held entry leaves on any unstalled edge, or when flushed away.
  always_comb begin
    cnt_d = cnt_q;
    if (ctrl_q.valid && (!stall || flush))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign wb_valid      = ctrl_q.valid;
  assign reg_write     = ctrl_q.reg_write;
  assign misalign_err  = ctrl_q.misalign;
  assign write_addr    = addr_q;
  assign write_data    = data_q;
  assign retired_count = cnt_q;

endmodule
